// File: rtl/execute_md_stage_pkg.sv
// Shared types for the execute stage: decoded control, ALU/M-extension op codes
// and the multi-cycle unit state encoding.
package common;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_type;

  // MD_ prefix keeps these distinct from the MUL/DIV state names below
  typedef enum logic [3:0] {
    MD_NONE, MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_type;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} ex_state_type;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       Branch;
    logic       ALUSrc;
    alu_op_type ALUOp;
    md_op_type  md_op;
  } control_type;

  function automatic logic is_mul_op(input md_op_type op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
  endfunction

  function automatic logic is_rem_op(input md_op_type op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/execute_md_stage_alu.sv
// Single-cycle integer ALU for the execute stage.
module alu
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_type      op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [$clog2(XLEN)-1:0] shamt;

  always_comb begin
    shamt  = b[$clog2(XLEN)-1:0];
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/execute_md_stage_mul_div_unit.sv
// Multi-cycle RV32M unit: fixed-latency multiply and radix-2 restoring divide,
// with divide-by-zero and signed overflow resolved at start.
module mul_div_unit
  import common::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  md_op_type       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_MAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES : XLEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  ex_state_type     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_type        op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  div_q, div_d, quo_q, quo_d, rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             sgn_div, neg_a, neg_b;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             a_sx, b_sx;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0]  mul_res;
  logic [XLEN:0]    shifted, trial;
  logic [XLEN-1:0]  quo_n, rem_n, div_res;

  always_comb begin
    // start-time operand conditioning
    sgn_div = (op == MD_DIV) || (op == MD_REM);
    neg_a   = sgn_div & a[XLEN-1];
    neg_b   = sgn_div & b[XLEN-1];
    mag_a   = neg_a ? -a : a;
    mag_b   = neg_b ? -b : b;

    // sign-extend to 2*XLEN so one unsigned multiply covers every signedness mix
    a_sx    = ((op_q == MD_MULH) || (op_q == MD_MULHSU)) & a_q[XLEN-1];
    b_sx    = (op_q == MD_MULH) & b_q[XLEN-1];
    ext_a   = {{XLEN{a_sx}}, a_q};
    ext_b   = {{XLEN{b_sx}}, b_q};
    prod    = ext_a * ext_b;
    mul_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, div_q};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
    div_res = is_rem_op(op_q) ? (neg_rem_q ? -rem_n : rem_n)
                              : (neg_quo_q ? -quo_n : quo_n);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    div_d     = div_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    busy      = (state_q == MUL) || (state_q == DIV);
    done      = (state_q == DONE);
    result    = result_q;

    case (state_q)
      IDLE: if (start) begin
        op_d  = op;
        a_d   = a;
        b_d   = b;
        cnt_d = '0;
        if (is_mul_op(op)) begin
          state_d = MUL;
        end else if (b == '0) begin
          result_d = is_rem_op(op) ? a : '1;
          state_d  = DONE;
        end else if (sgn_div && (a == MIN_NEG) && (b == '1)) begin
          result_d = is_rem_op(op) ? '0 : MIN_NEG;
          state_d  = DONE;
        end else begin
          quo_d     = mag_a;
          div_d     = mag_b;
          rem_d     = '0;
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          state_d   = DIV;
        end
      end
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
          result_d = mul_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DIV: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = div_res;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= MD_NONE;
      a_q       <= '0;
      b_q       <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      div_q     <= div_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: rtl/execute_md_stage.sv
// Execute stage with operand forwarding, single-cycle ALU and multi-cycle RV32M.
// Define RV_FORWARDING_EN to enable the MEM/WB forwarding muxes.
module execute_md_stage
  import common::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  input  control_type           control_in,
  input  logic [XLEN-1:0]       data1,
  input  logic [XLEN-1:0]       data2,
  input  logic [XLEN-1:0]       immediate_data,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  output logic                  stall_out,
  output logic                  valid_out,
  output control_type           control_out,
  output logic                  zero_flag,
  output logic [XLEN-1:0]       alu_data,
  output logic [XLEN-1:0]       memory_data,
  output logic [REG_ADDR_W-1:0] rd_out
);

  logic [XLEN-1:0] op_a, op_b, alu_b, alu_res, mdu_res;
  logic            alu_zero, is_md, mdu_busy, mdu_done, mdu_idle, mdu_start;

  logic                  valid_out_q, valid_out_d, zero_flag_q, zero_flag_d;
  control_type           control_out_q, control_out_d;
  logic [XLEN-1:0]       alu_data_q, alu_data_d, memory_data_q, memory_data_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;

`ifdef RV_FORWARDING_EN
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs, input logic [XLEN-1:0] rf,
    input logic mv, input logic [REG_ADDR_W-1:0] mrd, input logic [XLEN-1:0] mdat,
    input logic wv, input logic [REG_ADDR_W-1:0] wrd, input logic [XLEN-1:0] wdat);
    if (rs != '0 && mv && mrd == rs) return mdat;
    if (rs != '0 && wv && wrd == rs) return wdat;
    return rf;
  endfunction

  always_comb begin
    op_a = fwd_sel(rs1_in, data1, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    op_b = fwd_sel(rs2_in, data2, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                   fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_in, rs2_in, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data};
  assign op_a = data1;
  assign op_b = data2;
`endif

  assign alu_b     = control_in.ALUSrc ? immediate_data : op_b;
  assign is_md     = (control_in.md_op != MD_NONE);
  assign mdu_idle  = !mdu_busy && !mdu_done;
  assign mdu_start = valid_in && is_md && mdu_idle && !flush;
  assign stall_out = !rst && ((valid_in && is_md && mdu_idle) || mdu_busy);

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .op     (control_in.ALUOp),
    .result (alu_res),
    .zero   (alu_zero)
  );

  mul_div_unit #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (mdu_start),
    .op     (control_in.md_op),
    .a      (op_a),
    .b      (op_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_res)
  );

  // Anything that does not retire this cycle becomes an all-zero bubble
  always_comb begin
    valid_out_d   = 1'b0;
    control_out_d = '0;
    zero_flag_d   = 1'b0;
    alu_data_d    = '0;
    memory_data_d = '0;
    rd_out_d      = '0;
    if (flush) begin
      valid_out_d = 1'b0;
    end else if (mdu_done) begin
      valid_out_d   = 1'b1;
      control_out_d = control_in;
      zero_flag_d   = (mdu_res == '0);
      alu_data_d    = mdu_res;
      rd_out_d      = rd_in;
    end else if (valid_in && !is_md && mdu_idle) begin
      valid_out_d   = 1'b1;
      control_out_d = control_in;
      zero_flag_d   = alu_zero;
      alu_data_d    = alu_res;
      memory_data_d = op_b;
      rd_out_d      = rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_q   <= 1'b0;
      control_out_q <= '0;
      zero_flag_q   <= 1'b0;
      alu_data_q    <= '0;
      memory_data_q <= '0;
      rd_out_q      <= '0;
    end else begin
      valid_out_q   <= valid_out_d;
      control_out_q <= control_out_d;
      zero_flag_q   <= zero_flag_d;
      alu_data_q    <= alu_data_d;
      memory_data_q <= memory_data_d;
      rd_out_q      <= rd_out_d;
    end
  end

  assign valid_out   = valid_out_q;
  assign control_out = control_out_q;
  assign zero_flag   = zero_flag_q;
  assign alu_data    = alu_data_q;
  assign memory_data = memory_data_q;
  assign rd_out      = rd_out_q;

endmodule

// File: tb/tb_execute_md_stage.sv
// Directed bench for execute_md_stage: ALU vector table, M-extension sequences,
// flush and reset corner cases.
module tb_execute_md_stage;
  import common::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int MC   = 2;
`ifdef RV_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, valid_in;
  control_type control_in, control_out;
  logic [XLEN-1:0] data1, data2, immediate_data, fwd_mem_data, fwd_wb_data;
  logic [RW-1:0] rs1_in, rs2_in, rd_in, fwd_mem_rd, fwd_wb_rd, rd_out;
  logic fwd_mem_valid, fwd_wb_valid;
  logic stall_out, valid_out, zero_flag;
  logic [XLEN-1:0] alu_data, memory_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_md_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .control_in(control_in),
    .data1(data1), .data2(data2), .immediate_data(immediate_data),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .stall_out(stall_out), .valid_out(valid_out), .control_out(control_out),
    .zero_flag(zero_flag), .alu_data(alu_data), .memory_data(memory_data), .rd_out(rd_out)
  );

  typedef struct {
    alu_op_type      op;
    logic            src;
    logic [RW-1:0]   rs1, rs2;
    logic [XLEN-1:0] d1, d2, imm;
    logic            mv;
    logic [RW-1:0]   mrd;
    logic [XLEN-1:0] mdat;
    logic            wv;
    logic [RW-1:0]   wrd;
    logic [XLEN-1:0] wdat;
    logic [XLEN-1:0] exp_alu, exp_mem;
    logic            exp_z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic control_type mk_ctrl(input alu_op_type op, input logic src,
                                          input md_op_type md);
    control_type c;
    c = '0;
    c.RegWrite = 1'b1;
    c.ALUSrc   = src;
    c.ALUOp    = op;
    c.md_op    = md;
    return c;
  endfunction

  task automatic clear_fwd();
    fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    rs1_in = 0; rs2_in = 0;
  endtask

  // Issue an M op, hold it until it retires, check latency, stall length and result
  task automatic run_md(input string nm, input md_op_type op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    int stl = 1;
    clear_fwd();
    valid_in = 1; control_in = mk_ctrl(ALU_ADD, 1'b0, op);
    data1 = a; data2 = b; immediate_data = 32'h0; rd_in = 5'd9;
    #1;
    chk({nm, "_stall_acc"}, 32'(stall_out), 32'd1);
    do begin
      tick();
      lat++;
      if (!valid_out && stall_out) stl++;
    end while (!valid_out && lat < 200);
    valid_in = 0; control_in = '0;
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_stall_cycles"}, stl, exp_lat - 1);
    chk({nm, "_result"}, alu_data, exp);
    chk({nm, "_zero"}, 32'(zero_flag), 32'(exp == 32'h0));
    chk({nm, "_rd"}, 32'(rd_out), 32'd9);
    #1;
    chk({nm, "_stall_after"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int retired;
    vecs[0]  = '{ALU_ADD,  1, 0, 0, 32'd5,        32'd0,        32'd7, 0, 0, 0, 0, 0, 0, 32'd12,        32'd0, 0};
    vecs[1]  = '{ALU_SUB,  0, 0, 0, 32'd10,       32'd10,       32'd0, 0, 0, 0, 0, 0, 0, 32'd0,         32'd10, 1};
    vecs[2]  = '{ALU_AND,  0, 0, 0, 32'hF0F0,     32'hFF00,     32'd0, 0, 0, 0, 0, 0, 0, 32'hF000,      32'hFF00, 0};
    vecs[3]  = '{ALU_SLT,  0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0, 0, 0, 0, 0, 0, 0, 32'd1,         32'd1, 0};
    vecs[4]  = '{ALU_SLTU, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0, 0, 0, 0, 0, 0, 0, 32'd0,         32'd1, 1};
    vecs[5]  = '{ALU_SRA,  1, 0, 0, 32'h80000000, 32'd0,        32'd4, 0, 0, 0, 0, 0, 0, 32'hF8000000,  32'd0, 0};
    vecs[6]  = '{ALU_SLL,  1, 0, 0, 32'd1,        32'd0,        32'd31,0, 0, 0, 0, 0, 0, 32'h80000000,  32'd0, 0};
    vecs[7]  = '{ALU_XOR,  0, 0, 0, 32'hAAAA5555, 32'hFFFF0000, 32'd0, 0, 0, 0, 0, 0, 0, 32'h55555555,  32'hFFFF0000, 0};
    // forwarding: MEM beats WB, x0 never forwarded, WB used when MEM misses
    vecs[8]  = '{ALU_ADD,  1, 5'd3, 0, 32'd0, 32'd0, 32'd0, 1, 5'd3, 32'h10, 1, 5'd3, 32'h20,
                 FWD ? 32'h10 : 32'h0, 32'd0, !FWD};
    vecs[9]  = '{ALU_ADD,  1, 5'd0, 0, 32'd0, 32'd0, 32'd0, 1, 5'd0, 32'h10, 1, 5'd0, 32'h20,
                 32'h0, 32'd0, 1};
    vecs[10] = '{ALU_ADD,  1, 5'd3, 0, 32'd0, 32'd0, 32'd0, 1, 5'd4, 32'h10, 1, 5'd3, 32'h20,
                 FWD ? 32'h20 : 32'h0, 32'd0, !FWD};
    // memory_data follows forwarded B, not the immediate
    vecs[11] = '{ALU_ADD,  1, 5'd0, 5'd5, 32'd1, 32'd1, 32'd2, 1, 5'd5, 32'h55, 0, 0, 0,
                 32'd3, FWD ? 32'h55 : 32'd1, 0};

    rst = 1; flush = 0; valid_in = 0; control_in = '0;
    data1 = 0; data2 = 0; immediate_data = 0; rd_in = 0;
    clear_fwd();
    repeat (2) tick();
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_alu", alu_data, 0);
    chk("rst_mem", memory_data, 0);
    chk("rst_zero", 32'(zero_flag), 0);
    chk("rst_ctrl", 32'(control_out), 0);
    chk("rst_rd", 32'(rd_out), 0);
    rst = 0;
    tick();

    for (int i = 0; i < 12; i++) begin
      valid_in = 1;
      control_in = mk_ctrl(vecs[i].op, vecs[i].src, MD_NONE);
      rs1_in = vecs[i].rs1; rs2_in = vecs[i].rs2;
      data1 = vecs[i].d1; data2 = vecs[i].d2; immediate_data = vecs[i].imm;
      fwd_mem_valid = vecs[i].mv; fwd_mem_rd = vecs[i].mrd; fwd_mem_data = vecs[i].mdat;
      fwd_wb_valid = vecs[i].wv; fwd_wb_rd = vecs[i].wrd; fwd_wb_data = vecs[i].wdat;
      rd_in = 5'(i + 1);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_out), 0);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 1);
      chk($sformatf("v%0d_alu", i), alu_data, vecs[i].exp_alu);
      chk($sformatf("v%0d_mem", i), memory_data, vecs[i].exp_mem);
      chk($sformatf("v%0d_zero", i), 32'(zero_flag), 32'(vecs[i].exp_z));
      chk($sformatf("v%0d_rd", i), 32'(rd_out), i + 1);
      chk($sformatf("v%0d_ctrl", i), 32'(control_out),
          32'(mk_ctrl(vecs[i].op, vecs[i].src, MD_NONE)));
    end
    valid_in = 0; control_in = '0;
    clear_fwd();
    tick();
    chk("bubble_valid", 32'(valid_out), 0);

    run_md("div_neg",   MD_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, XLEN + 2);
    run_md("rem_neg",   MD_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, XLEN + 2);
    run_md("divu",      MD_DIVU,   32'd100,      32'd7,        32'd14,       XLEN + 2);
    run_md("remu",      MD_REMU,   32'd100,      32'd7,        32'd2,        XLEN + 2);
    run_md("divu_zero", MD_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 2);
    run_md("remu_zero", MD_REMU,   32'd9,        32'd0,        32'd9,        2);
    run_md("rem_ovf",   MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2);
    run_md("div_ovf",   MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_md("mulhu",     MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MC + 2);
    run_md("mulhsu",    MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MC + 2);
    run_md("mulh",      MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MC + 2);
    run_md("mul",       MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MC + 2);

    // flush during the 5th DIV cycle: nothing retires, stage accepts again at once
    valid_in = 1; control_in = mk_ctrl(ALU_ADD, 1'b0, MD_DIVU);
    data1 = 32'd100; data2 = 32'd7; rd_in = 5'd12;
    repeat (5) tick();
    chk("flush_pre_stall", 32'(stall_out), 1);
    flush = 1; valid_in = 0; control_in = '0;
    tick();
    flush = 0;
    chk("flush_stall", 32'(stall_out), 0);
    chk("flush_valid", 32'(valid_out), 0);
    retired = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      tick();
      if (valid_out) retired++;
    end
    chk("flush_no_retire", retired, 0);
    valid_in = 1; control_in = mk_ctrl(ALU_ADD, 1'b1, MD_NONE);
    data1 = 32'd1; immediate_data = 32'd2; rd_in = 5'd13;
    tick();
    chk("flush_idle_valid", 32'(valid_out), 1);
    chk("flush_idle_alu", alu_data, 32'd3);
    valid_in = 0; control_in = '0;
    tick();

    // reset in the middle of a multiply
    valid_in = 1; control_in = mk_ctrl(ALU_ADD, 1'b0, MD_MULHU);
    data1 = 32'hFFFFFFFF; data2 = 32'hFFFFFFFF; rd_in = 5'd14;
    tick();
    chk("mul_busy_stall", 32'(stall_out), 1);
    rst = 1; valid_in = 0; control_in = '0;
    tick();
    chk("rstmid_valid", 32'(valid_out), 0);
    chk("rstmid_stall", 32'(stall_out), 0);
    chk("rstmid_alu", alu_data, 0);
    chk("rstmid_rd", 32'(rd_out), 0);
    chk("rstmid_ctrl", 32'(control_out), 0);
    rst = 0;
    retired = 0;
    for (int i = 0; i < MC + 4; i++) begin
      tick();
      if (valid_out || stall_out) retired++;
    end
    chk("rstmid_no_retire", retired, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_md_stage.md
# execute_md_stage

Parametrised successor to the RV32I execute stage: selects operands with MEM/WB forwarding, runs single-cycle ALU operations and multi-cycle RV32M multiply/divide, and registers results into the EX/MEM pipeline register. It sits between the ID/EX and EX/MEM registers. While a multi-cycle operation is in flight it holds the upstream pipeline with `stall_out`.

## Interface
- `XLEN`, 32, datapath width.
- `REG_ADDR_W`, 5, register index width.
- `MUL_CYCLES`, 2, multiply busy cycles; legal values are ≥1.

Ports (clock and reset first):
- `clk` in 1 — clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `flush` in 1 — kills any in-flight op; the EX/MEM output becomes a bubble.
- `valid_in` in 1 — the ID/EX register holds a live instruction.
- `control_in` in `control_type` — decoded control, including `ALUSrc`, `ALUOp` and `md_op`.
- `data1`, `data2` in XLEN — register-file operands.
- `immediate_data` in XLEN — immediate operand.
- `rs1_in`, `rs2_in`, `rd_in` in REG_ADDR_W — source and destination indices.
- `fwd_mem_valid` in 1; `fwd_mem_rd` in REG_ADDR_W; `fwd_mem_data` in XLEN — forwarding source from MEM.
- `fwd_wb_valid` in 1; `fwd_wb_rd` in REG_ADDR_W; `fwd_wb_data` in XLEN — forwarding source from WB.
- `stall_out` out 1 — upstream must hold ID/EX contents while this is high.
- `valid_out` out 1; `control_out` out `control_type`; `zero_flag` out 1; `alu_data` out XLEN; `memory_data` out XLEN; `rd_out` out REG_ADDR_W — registered EX/MEM outputs.

## Operation
- Forwarding applies per operand; A uses `rs1_in`/`data1`, B uses `rs2_in`/`data2`.
  - If rs≠0, `fwd_mem_valid` is set and `fwd_mem_rd`==rs, take `fwd_mem_data`.
  - Otherwise, if the same holds for WB, take `fwd_wb_data`.
  - Otherwise take the register value.
  - MEM has priority over WB.
- Right ALU operand = `immediate_data` when `ALUSrc` is set, else forwarded B.
- `memory_data` = forwarded B, never the immediate.
- FSM states:
  - IDLE: with `valid_in` and `md_op`==MD_NONE, the ALU result loads the output register and the state stays IDLE.
    - With `valid_in` and an M op, operands are latched and `stall_out`=1.
    - Next state is MUL for a multiply, DIV for a divide, or DONE for a divide special case.
  - MUL: counts `MUL_CYCLES`, then goes to DONE.
  - DIV: radix-2 restoring divide on latched magnitudes, XLEN iterations, then DONE. Sign fix-up is applied on exit.
  - DONE: `stall_out`=0; the held instruction retires and the MDU result loads the output register. The state returns to IDLE.
- Multiply ops:
  - MUL returns the low XLEN bits.
  - MULH / MULHSU / MULHU return the high XLEN bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide special cases, handled with no iteration:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - DIV/REM with −2^(XLEN−1) / −1: quotient −2^(XLEN−1), remainder 0.
- For multiply/divide results, `zero_flag` = (result==0).
- `control_out` and `rd_out` register the held `control_in` and `rd_in`.
- Bubble: whenever `stall_out`=1, or `valid_in`=0, the next cycle has `valid_out`=0.

## Timing
- Reset: state IDLE, counter 0, and all outputs 0, including `valid_out`, `stall_out`, `zero_flag` and `control_out`.
- `stall_out` is combinational. It is high in the acceptance cycle of an M op and in every MUL/DIV cycle, and low in DONE and in IDLE for non-M ops.
- Latency from acceptance cycle T to `valid_out`:
  - ALU op: T+1.
  - Multiply: T+`MUL_CYCLES`+2.
  - Normal divide: T+XLEN+2.
  - Special-case divide: T+2.
- Forwarding inputs are sampled only in the acceptance cycle; later changes do not affect an in-flight op.
- `flush` has priority over everything except `rst`. Next cycle: state IDLE, `valid_out`=0, `stall_out`=0.
- Reset asserted mid-operation aborts the op; nothing retires.

## Configuration
- `RV_FORWARDING_EN` defined: forwarding muxes as described above.
- Undefined: operand A = `data1`, B = `data2`. The forwarding ports remain in the interface and are ignored.

## Structure
- Shared package `common` holds:
  - `md_op_type` enum: MD_NONE, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - The `md_op` field added to `control_type`.
  - `ex_state_type` enum: IDLE, MUL, DIV, DONE.
- Sub-module `mul_div_unit`:
  - Contains the FSM, counter and operand/result registers.
  - Handshake: start, op, a, b in; busy, done, result out.
- The existing `alu` module is instantiated unchanged.

## Test plan
- ALU add, `ALUSrc`=1: data1=5, imm=7 → `alu_data`=12 with `valid_out`=1 one cycle later; `stall_out` stays 0.
- Forwarding: rs1=3, MEM rd=3 data=0x10, WB rd=3 data=0x20, data1=0 → A=0x10; with rs1=0 → A=0.
- DIV −20/3: `stall_out` high for XLEN+1 cycles, then quotient −6; REM gives −2.
- DIVU 9/0 → 0xFFFFFFFF with `valid_out` at T+2; REM 0x80000000/−1 → 0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE after `MUL_CYCLES`+2 cycles.
- `flush` on the 5th DIV cycle → next cycle IDLE, `stall_out`=0, no result retired; `rst` mid-MUL → all outputs 0.
